// File: rtl/adc128s052_emu.sv
// Behavioural emulator of an ADC128S052 SPI slave: the master selects a channel per frame and
// reads back a 16-bit word. Define ADC_EMU_FRAME_ERR_EN to build short-frame detection.
module adc128s052_emu #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        adc_cs_n,
    input  logic        adc_sclk,
    input  logic        adc_din,
    output logic        adc_dout,
    input  logic [95:0] ch_data,
    output logic [2:0]  cur_ch,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
    logic                   cs_dly_q, sclk_dly_q;
    logic                   cs_s, sclk_s, din_s;
    logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;

    state_e      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  addr_q, addr_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        done_q, done_d;
    logic [11:0] ch_arr [8];

    // Presetting to 1 makes reset look like an idle bus: CS inactive, SCLK high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            din_sync_q  <= '1;
            cs_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], adc_din};
            cs_dly_q    <= cs_s;
            sclk_dly_q  <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_dly_q & ~cs_s;
    assign cs_rise   = ~cs_dly_q & cs_s;
    assign sclk_fall = sclk_dly_q & ~sclk_s;
    assign sclk_rise = ~sclk_dly_q & sclk_s;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ch_arr[i] = ch_data[12*i +: 12];
        end
    end

`ifdef ADC_EMU_FRAME_ERR_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        cur_ch_d = cur_ch_q;
        done_d   = 1'b0;
`ifdef ADC_EMU_FRAME_ERR_EN
        err_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                shreg_d = '0;
                if (cs_fall) begin
                    // Track/hold: the word is frozen at CS fall.
                    state_d = StShift;
                    shreg_d = {4'b0000, ch_arr[cur_ch_q]};
                    cnt_d   = '0;
                end
            end
            StShift: begin
                // CS rise wins over any coincident SCLK edge.
                if (cs_rise) begin
                    state_d = StIdle;
                    shreg_d = '0;
`ifdef ADC_EMU_FRAME_ERR_EN
                    err_d   = 1'b1;
`endif
                end else if (sclk_fall) begin
                    shreg_d = {shreg_q[14:0], 1'b0};
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q >= 5'd2 && cnt_q <= 5'd4) begin
                        addr_d = {addr_q[1:0], din_s};
                    end
                    if (cnt_q == 5'd15) begin
                        state_d = StHold;
                        shreg_d = '0;
                    end
                end
            end
            StHold: begin
                shreg_d = '0;
                if (cs_rise) begin
                    state_d  = StIdle;
                    cur_ch_d = addr_q;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            cur_ch_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            cur_ch_q <= cur_ch_d;
            done_q   <= done_d;
        end
    end

`ifdef ADC_EMU_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign adc_dout   = shreg_q[15];
    assign busy       = (state_q != StIdle);
    assign cur_ch     = cur_ch_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_adc128s052_emu.sv
// Self-checking bench for adc128s052_emu: an SPI master drives directed frames while a
// pin-level model predicts busy, pulses, cur_ch and the serial word.
module tb_adc128s052_emu;

    localparam int SYNC = 2;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cs_n, sclk, din;
    logic        dout;
    logic [95:0] ch_data;
    logic [2:0]  cur_ch;
    logic        busy, frame_done, frame_err;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [3:0] cs_hist;
    logic       prev_busy;
    logic [2:0] m_cur_ch;
    logic [2:0] frame_addr = 3'd0;
    int         frame_rises = 0;
    int         done_seen = 0;
    int         err_seen = 0;

    adc128s052_emu #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .adc_cs_n  (cs_n),
        .adc_sclk  (sclk),
        .adc_din   (din),
        .adc_dout  (dout),
        .ch_data   (ch_data),
        .cur_ch    (cur_ch),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // busy follows the CS pin SYNC clocks late; a busy fall ends a frame whose outcome is set
    // by how many SCLK rises the master issued.
    always @(posedge clk) begin
        logic exp_busy, fell, exp_done, exp_err;
        #1;
        if (!rstn) begin
            cs_hist   = '1;
            prev_busy = 1'b0;
            m_cur_ch  = 3'd0;
            check("rst_busy", busy, 0);
            check("rst_done", frame_done, 0);
            check("rst_err", frame_err, 0);
            check("rst_cur_ch", cur_ch, 0);
            check("rst_dout", dout, 0);
        end else begin
            cs_hist  = {cs_hist[2:0], cs_n};
            exp_busy = !cs_hist[SYNC];
            fell     = prev_busy && !exp_busy;
            exp_done = fell && (frame_rises >= 16);
`ifdef ADC_EMU_FRAME_ERR_EN
            exp_err  = fell && (frame_rises < 16);
`else
            exp_err  = 1'b0;
`endif
            if (exp_done) m_cur_ch = frame_addr;
            check("busy", busy, exp_busy);
            check("frame_done", frame_done, exp_done);
            check("frame_err", frame_err, exp_err);
            check("cur_ch", cur_ch, m_cur_ch);
            if (!exp_busy) check("idle_dout", dout, 0);
            if (frame_done === 1'b1) done_seen++;
            if (frame_err === 1'b1) err_seen++;
            prev_busy = exp_busy;
        end
    end

    task automatic do_frame(input int nrise, input logic [2:0] addr, input int chg_at,
                            output logic [15:0] word);
        logic [15:0] exp_word;
        exp_word    = {4'h0, ch_data[12*int'(m_cur_ch) +: 12]};
        word        = '0;
        frame_addr  = addr;
        frame_rises = nrise;
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 1; i <= nrise; i++) begin
            if (i == chg_at) ch_data[24 +: 12] = 12'h000;
            if (i <= 16) begin
                word[16-i] = dout;
                check("dout_bit", dout, exp_word[16-i]);
            end else begin
                check("hold_dout", dout, 0);
            end
            din  = (i >= 3 && i <= 5) ? addr[5-i] : 1'b0;
            sclk = 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
        end
        if (nrise >= 16) begin
            check("hold_dout_end", dout, 0);
            cs_n = 1'b1;
        end else begin
            // SCLK fall together with CS rise: CS must win.
            sclk = 1'b0;
            cs_n = 1'b1;
            wait_clk(HALF);
            sclk = 1'b1;
        end
        wait_clk(8);
        if (nrise >= 16) check("word", word, exp_word);
    endtask

    initial begin
        logic [15:0] w;
        rstn = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b1;
        din  = 1'b0;
        ch_data = {12'hDEF, 12'hABC, 12'h123, 12'h789, 12'h456, 12'hFFF, 12'h3C7, 12'hA5C};
        #2 rstn = 1'b0;
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(4);

        do_frame(16, 3'd5, 0, w);
        check("f1_word", w, 16'h0A5C);
        check("f1_cur_ch", cur_ch, 3'd5);
        check("f1_done_cnt", done_seen, 1);

        do_frame(16, 3'd2, 0, w);
        check("f2_word", w, 16'h0123);
        check("f2_cur_ch", cur_ch, 3'd2);

        do_frame(16, 3'd1, 6, w);
        check("f3_word_held", w, 16'h0FFF);
        check("f3_cur_ch", cur_ch, 3'd1);
        check("f3_done_cnt", done_seen, 3);

        do_frame(9, 3'd7, 0, w);
        check("f4_cur_ch", cur_ch, 3'd1);
        check("f4_done_cnt", done_seen, 3);
`ifdef ADC_EMU_FRAME_ERR_EN
        check("f4_err_cnt", err_seen, 1);
`else
        check("f4_err_cnt", err_seen, 0);
`endif

        do_frame(20, 3'd3, 0, w);
        check("f5_word", w, 16'h03C7);
        check("f5_cur_ch", cur_ch, 3'd3);
        check("f5_done_cnt", done_seen, 4);

        // Reset during bit 8 of a frame.
        frame_rises = 8;
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 1; i <= 7; i++) begin
            sclk = 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
        end
        sclk = 1'b0;
        wait_clk(2);
        rstn = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b1;
        wait_clk(3);
        check("r_dout", dout, 0);
        check("r_busy", busy, 0);
        check("r_cur_ch", cur_ch, 0);
        rstn = 1'b1;
        wait_clk(6);
        check("r_done_cnt", done_seen, 4);
`ifdef ADC_EMU_FRAME_ERR_EN
        check("r_err_cnt", err_seen, 1);
`else
        check("r_err_cnt", err_seen, 0);
`endif

        do_frame(16, 3'd4, 0, w);
        check("f6_word", w, 16'h0A5C);
        check("f6_cur_ch", cur_ch, 3'd4);
        check("f6_done_cnt", done_seen, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
